// File: rtl/bram_dp_param.sv
// bram_dp_param: true dual-port RAM with post-reset clear sweep,
// 1/2-cycle read pipeline and per-port read/write-first modes.
module bram_dp_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 15,
  parameter int RD_LAT    = 1,
  parameter int WR_MODE_A = 0,
  parameter int WR_MODE_B = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  output logic              valida,
  input  logic              enb,
  input  logic              web,
  input  logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] dinb,
  output logic [DATA_W-1:0] doutb,
  output logic              validb,
  output logic              init_done,
  output logic              collision
);
  localparam int  DEPTH = 2**ADDR_W;
  localparam bit  TWO   = (RD_LAT == 2);

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("bram_dp_param: RD_LAT must be 1 or 2");
  end

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                init_done_q, init_done_d;
  logic                collision_q, collision_d;
  logic [DATA_W-1:0]   p1a_q, p1a_d, p1b_q, p1b_d;
  logic                v1a_q, v1a_d, v1b_q, v1b_d;
  logic [DATA_W-1:0]   douta_q, douta_d, doutb_q, doutb_d;
  logic                valida_q, valida_d, validb_q, validb_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                run, clr, acc_a, acc_b, wr_a, wr_b;
  logic [DATA_W-1:0]   rd_a, rd_b;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    unique case (state_q)
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d     = S_RUN;
          init_done_d = 1'b1;
        end
      end
      S_RUN: begin
      end
    endcase
  end

  always_comb begin
    run   = (state_q == S_RUN);
    clr   = !run;
    acc_a = run && ena;
    acc_b = run && enb;
    wr_a  = acc_a && wea;
    wr_b  = acc_b && web;
    // mem_q is sampled before this edge's writes: cross-port reads see old data
    rd_a  = mem_q[addra];
    rd_b  = mem_q[addrb];
    if (WR_MODE_A != 0 && wr_a) rd_a = dina;
    if (WR_MODE_B != 0 && wr_b) rd_b = dinb;
    collision_d = wr_a && wr_b && (addra == addrb);
    v1a_d = acc_a;
    v1b_d = acc_b;
    p1a_d = acc_a ? rd_a : p1a_q;
    p1b_d = acc_b ? rd_b : p1b_q;
    if (TWO) begin
      valida_d = v1a_q;
      validb_d = v1b_q;
      douta_d  = v1a_q ? p1a_q : douta_q;
      doutb_d  = v1b_q ? p1b_q : doutb_q;
    end else begin
      valida_d = acc_a;
      validb_d = acc_b;
      douta_d  = acc_a ? rd_a : douta_q;
      doutb_d  = acc_b ? rd_b : doutb_q;
    end
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state_q     <= S_CLEAR;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      collision_q <= 1'b0;
      p1a_q       <= '0;
      p1b_q       <= '0;
      v1a_q       <= 1'b0;
      v1b_q       <= 1'b0;
      douta_q     <= '0;
      doutb_q     <= '0;
      valida_q    <= 1'b0;
      validb_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      collision_q <= collision_d;
      p1a_q       <= p1a_d;
      p1b_q       <= p1b_d;
      v1a_q       <= v1a_d;
      v1b_q       <= v1b_d;
      douta_q     <= douta_d;
      doutb_q     <= doutb_d;
      valida_q    <= valida_d;
      validb_q    <= validb_d;
    end
  end

  // port A is written last so it wins a same-address collision
  always_ff @(posedge clka) begin
    if (clr)  mem_q[cnt_q] <= INIT_VAL;
    if (wr_b) mem_q[addrb] <= dinb;
    if (wr_a) mem_q[addra] <= dina;
  end

  assign douta     = douta_q;
  assign doutb     = doutb_q;
  assign valida    = valida_q;
  assign validb    = validb_q;
  assign init_done = init_done_q;
  assign collision = collision_q;
endmodule

// File: tb/tb_bram_dp_param.sv
// tb_bram_dp_param: two RAM configurations driven in lockstep,
// checked by a queue scoreboard against an array model.
module tb_bram_dp_param;
  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  logic       clk = 0;
  logic       rst = 1;
  logic       ena = 0, wea = 0, enb = 0, web = 0;
  logic [3:0] addra = 0, addrb = 0;
  logic [7:0] dina = 0, dinb = 0;

  logic [7:0] douta0, doutb0, douta1, doutb1;
  logic       valida0, validb0, valida1, validb1;
  logic       idn0, idn1, col0, col1;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int rel_cyc = 0;
  int rise [2];

  int         lat   [2] = '{1, 2};
  bit         wma   [2] = '{1'b0, 1'b1};
  bit         wmb   [2] = '{1'b1, 1'b0};
  logic [7:0] initv [2] = '{8'h00, 8'hC3};
  logic [7:0] rm    [2][16];

  exp_t sb [4][$];
  int   cq [2][$];
  exp_t mon_e;

  logic       vld  [4];
  logic [7:0] dq   [4];
  logic [7:0] last [4];
  logic       idn  [2];
  logic       col  [2];

  assign vld[0] = valida0;
  assign vld[1] = validb0;
  assign vld[2] = valida1;
  assign vld[3] = validb1;
  assign dq[0]  = douta0;
  assign dq[1]  = doutb0;
  assign dq[2]  = douta1;
  assign dq[3]  = doutb1;
  assign idn[0] = idn0;
  assign idn[1] = idn1;
  assign col[0] = col0;
  assign col[1] = col1;

  bram_dp_param #(
    .DATA_W(8), .ADDR_W(4), .RD_LAT(1),
    .WR_MODE_A(0), .WR_MODE_B(1), .INIT_VAL(8'h00)
  ) dut0 (
    .clka(clk), .rsta(rst),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(douta0), .valida(valida0),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
    .doutb(doutb0), .validb(validb0),
    .init_done(idn0), .collision(col0)
  );

  bram_dp_param #(
    .DATA_W(8), .ADDR_W(4), .RD_LAT(2),
    .WR_MODE_A(1), .WR_MODE_B(0), .INIT_VAL(8'hC3)
  ) dut1 (
    .clka(clk), .rsta(rst),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(douta1), .valida(valida1),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
    .doutb(doutb1), .validb(validb1),
    .init_done(idn1), .collision(col1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) last[i] = dq[i];
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (vld[i]) begin
          tests++;
          if (sb[i].size() == 0) begin
            fails++;
            $display("FAIL unexpected_valid sb%0d cyc=%0d dout=%h",
                     i, cyc, dq[i]);
          end else begin
            mon_e = sb[i].pop_front();
            if (mon_e.due != cyc || mon_e.data !== dq[i]) begin
              fails++;
              $display("FAIL read sb%0d got %h@%0d exp %h@%0d",
                       i, dq[i], cyc, mon_e.data, mon_e.due);
            end
          end
        end else begin
          if (sb[i].size() != 0 && sb[i][0].due <= cyc) begin
            tests++;
            fails++;
            $display("FAIL missed_valid sb%0d cyc=%0d exp %h@%0d",
                     i, cyc, sb[i][0].data, sb[i][0].due);
            void'(sb[i].pop_front());
          end
          tests++;
          if (dq[i] !== last[i]) begin
            fails++;
            $display("FAIL hold sb%0d cyc=%0d got %h exp %h",
                     i, cyc, dq[i], last[i]);
          end
        end
        last[i] = dq[i];
      end
      for (int d = 0; d < 2; d++) begin
        if (col[d]) begin
          tests++;
          if (cq[d].size() != 0 && cq[d][0] == cyc) begin
            void'(cq[d].pop_front());
          end else begin
            fails++;
            $display("FAIL collision dut%0d cyc=%0d got 1 exp 0", d, cyc);
          end
        end else if (cq[d].size() != 0 && cq[d][0] <= cyc) begin
          tests++;
          fails++;
          $display("FAIL collision dut%0d cyc=%0d got 0 exp 1", d, cyc);
          void'(cq[d].pop_front());
        end
        if (idn[d] && rise[d] < 0) rise[d] = cyc;
      end
    end
  end

  task automatic issue(input logic ea, input logic wa,
                       input logic [3:0] aa, input logic [7:0] da,
                       input logic eb, input logic wb,
                       input logic [3:0] ab, input logic [7:0] db);
    exp_t e;
    ena = ea; wea = wa; addra = aa; dina = da;
    enb = eb; web = wb; addrb = ab; dinb = db;
    if (!rst && (cyc - rel_cyc) >= 16) begin
      for (int d = 0; d < 2; d++) begin
        if (ea) begin
          e.data = (wa && wma[d]) ? da : rm[d][aa];
          e.due  = cyc + lat[d];
          sb[2*d].push_back(e);
        end
        if (eb) begin
          e.data = (wb && wmb[d]) ? db : rm[d][ab];
          e.due  = cyc + lat[d];
          sb[2*d+1].push_back(e);
        end
        if (eb && wb) rm[d][ab] = db;
        if (ea && wa) rm[d][aa] = da;
        if (ea && wa && eb && wb && aa == ab) cq[d].push_back(cyc + 1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) issue(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_issue();
    issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)), 8'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)), 8'($urandom));
  endtask

  task automatic do_reset();
    logic [11:0] st [2];
    rst = 1;
    #1;
    st[0] = {douta0, valida0, validb0, idn0, col0};
    st[1] = {douta1, valida1, validb1, idn1, col1};
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (st[d] !== 12'h0 || dq[2*d+1] !== 8'h00) begin
        fails++;
        $display("FAIL reset_state dut%0d got %h/%h exp 000/00",
                 d, st[d], dq[2*d+1]);
      end
      cq[d].delete();
      sb[2*d].delete();
      sb[2*d+1].delete();
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    rel_cyc = cyc;
    for (int d = 0; d < 2; d++) begin
      rise[d] = -1;
      for (int a = 0; a < 16; a++) rm[d][a] = initv[d];
    end
  endtask

  task automatic wait_init();
    for (int k = 0; k < 20; k++) rand_issue();
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (rise[d] - rel_cyc != 16) begin
        fails++;
        $display("FAIL init_done_latency dut%0d got %0d exp 16",
                 d, rise[d] - rel_cyc);
      end
    end
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++)
      issue(1, 0, 4'(a), 0, 1, 0, 4'(15 - a), 0);
  endtask

  initial begin
    rise[0] = -1;
    rise[1] = -1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_reset();
    wait_init();
    read_all();
    issue(1, 1, 4'd3, 8'h5A, 0, 0, 0, 0);
    issue(1, 0, 4'd3, 8'h00, 0, 0, 0, 0);
    issue(1, 1, 4'd7, 8'h22, 0, 0, 0, 0);
    issue(1, 1, 4'd7, 8'h11, 0, 0, 0, 0);
    issue(1, 0, 4'd7, 8'h00, 0, 0, 0, 0);
    issue(1, 1, 4'd9, 8'hAA, 1, 1, 4'd9, 8'hBB);
    idle(1);
    issue(1, 0, 4'd9, 8'h00, 1, 0, 4'd9, 8'h00);
    issue(1, 0, 4'd2, 8'h00, 1, 1, 4'd2, 8'h33);
    issue(1, 0, 4'd2, 8'h00, 0, 0, 0, 0);
    idle(3);
    for (int k = 0; k < 300; k++) rand_issue();
    for (int k = 0; k < 20; k++) issue(1, 0, 4'(k), 0, 1, 0, 4'(k), 0);
    idle(4);
    do_reset();
    idle(5);
    do_reset();
    wait_init();
    read_all();
    idle(4);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (sb[i].size() != 0) begin
        fails++;
        $display("FAIL drain sb%0d got %0d pending exp 0",
                 i, sb[i].size());
      end
    end
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (cq[d].size() != 0) begin
        fails++;
        $display("FAIL drain_collision dut%0d got %0d pending exp 0",
                 d, cq[d].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
